relogio_contador_ajuste: RTL
============================

Name: relogio_contador_ajuste

Overview:
Timekeeping core that feeds the 8-digit display/adjust stage. It produces the binary seconds, minutes and hours values and the 2-bit adjust-mode code that drives field blinking. It runs a 24 h clock from a 1 Hz tick derived from clk_100MHz. Two push-buttons select the adjust mode and increment the selected field; a third decrements it. All buttons are debounced and edge-detected internally.

Parameters:
CLK_FREQ_HZ, 100_000_000, clk_100MHz frequency; the prescaler wraps at CLK_FREQ_HZ-1.
DEBOUNCE_CYCLES, 2_000_000, number of consecutive stable cycles required to accept a button level (20 ms at 100 MHz).

Ports:
clk_100MHz  in  1  system clock
reset  in  1  asynchronous, active-low reset
btn_modo  in  1  raw mode button, asynchronous, active-high
btn_inc  in  1  raw increment button, asynchronous, active-high
btn_dec  in  1  raw decrement button, asynchronous, active-high
segundos  out  6  seconds, 0..59, registered
minutos  out  6  minutes, 0..59, registered
horas  out  6  hours, 0..23, registered
modo_ajuste  out  2  00 run, 01 adjust seconds, 10 adjust minutes, 11 adjust hours
tick_1hz  out  1  one-cycle pulse when the prescaler wraps (RUN only)

Behaviour:
- Reset (reset=0, asynchronous): segundos=0, minutos=0, horas=0, modo_ajuste=00, tick_1hz=0, prescaler=0, debouncers cleared to level 0.
- Button path, per button:
  - 2-FF synchronizer.
  - Counter that requires DEBOUNCE_CYCLES consecutive equal samples before updating the stable level.
  - Rising-edge detector on the stable level, giving a 1-cycle pulse.
  - Latency from raw edge to pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Holding a button produces exactly one pulse. Release produces no pulse.
- FSM states: RUN(00), AJ_SEG(01), AJ_MIN(10), AJ_HORA(11). The state is output directly as modo_ajuste.
- FSM transitions:
  - A modo pulse advances RUN→AJ_SEG→AJ_MIN→AJ_HORA→RUN.
  - No other event changes the state.
- RUN:
  - Prescaler counts 0..CLK_FREQ_HZ-1. tick_1hz=1 in the cycle after the prescaler reaches CLK_FREQ_HZ-1, and the prescaler returns to 0.
  - On a tick, segundos increments. 59→0 carries to minutos; 59→0 carries to horas; 23→0 wraps. Example: 23:59:59 + tick → 00:00:00 in one cycle.
  - inc/dec pulses are ignored.
- Adjust states:
  - Prescaler is held at 0, tick_1hz=0, and no time advance occurs.
  - An inc pulse adds 1 to the selected field only, with wrap (sec/min 59→0, hour 23→0) and no carry into other fields.
  - A dec pulse subtracts 1 with wrap (0→59 or 0→23) and no borrow.
- Leaving AJ_HORA→RUN: the prescaler restarts at 0, so the first tick occurs a full CLK_FREQ_HZ cycles after the transition.
- Simultaneous events in the same cycle:
  - modo with inc or dec: modo wins, inc/dec discarded.
  - inc with dec: both discarded.
  - Tick with modo in RUN: the tick is applied to time, then the state moves to AJ_SEG.
- Reset asserted mid-debounce or mid-adjust returns everything to reset values immediately. No pulse is generated on reset release even if a button is held; its stable level must first reach 1 through debounce.
- Width rules:
  - All field arithmetic uses 6-bit compare-then-wrap. Values outside range are never produced.
  - Prescaler width is $clog2(CLK_FREQ_HZ).

Decomposition:
- Package relogio_pkg holds:
  - typedef enum logic [1:0] modo_t {RUN, AJ_SEG, AJ_MIN, AJ_HORA}, shared with the display stage's mode decoding.
  - Constants MAX_SEG=59, MAX_MIN=59, MAX_HORA=23.
- One sub-module, debounce_pulse (sync + stable counter + edge detector), parameterised by DEBOUNCE_CYCLES, instantiated three times.
- FSM, prescaler and time counters live in the top module.

Test Plan (CLK_FREQ_HZ=10, DEBOUNCE_CYCLES=4):
- Reset, run 600 cycles → tick_1hz exactly 60 pulses, 10 cycles apart; time reads 00:01:00; modo_ajuste=00.
- Force time to 23:59:59 via adjust, return to RUN, wait 10 cycles → 00:00:00 one cycle after tick.
- btn_modo bounce (toggle every 2 cycles for 10 cycles, then hold high 20 cycles) → exactly one modo pulse, modo_ajuste 00→01.
- In AJ_MIN with minutos=59, one inc press → minutos=0 and horas unchanged. Then dec press → minutos=59. Over 100 cycles segundos does not change.
- btn_inc and btn_dec raw edges aligned so pulses coincide → no field change. btn_modo aligned with btn_inc → mode advances, field unchanged.
- Assert reset=0 while in AJ_HORA with btn_inc held, then release reset with btn_inc still held → outputs 00:00:00, modo=00, and no inc effect after re-entering AJ_HORA until a new press.

Source files
------------

// File: rtl/relogio_pkg.sv
// Shared types and limits for the clock core
// and the display stage's mode decoding.
package relogio_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    AJ_SEG  = 2'b01,
    AJ_MIN  = 2'b10,
    AJ_HORA = 2'b11
  } modo_t;

  localparam logic [5:0] MAX_SEG  = 6'd59;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_HORA = 6'd23;

  function automatic logic [5:0] inc_wrap(
    input logic [5:0] v,
    input logic [5:0] lim
  );
    return (v >= lim) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec_wrap(
    input logic [5:0] v,
    input logic [5:0] lim
  );
    return (v == 6'd0 || v > lim) ? lim : v - 6'd1;
  endfunction

endpackage

// File: rtl/debounce_pulse.sv
// Button conditioner: 2-FF sync, stability
// counter and rising-edge one-cycle pulse.
module debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int unsigned CW =
    $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic          r_prev;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;

  // Bring the raw button into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after a full run of equal samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_s2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt    <= '0;
      r_stable <= r_s2;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered rising-edge detect on the stable level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= r_stable;
      r_pulse <= r_stable & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/relogio_contador_ajuste.sv
// 24 h timekeeping core with 1 Hz prescaler
// and button-driven field adjust modes.
module relogio_contador_ajuste
  import relogio_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_modo,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [5:0] segundos,
  output logic [5:0] minutos,
  output logic [5:0] horas,
  output logic [1:0] modo_ajuste,
  output logic       tick_1hz
);

  localparam int unsigned PW = $clog2(CLK_FREQ_HZ);
  localparam logic [PW-1:0] PRE_MAX =
    PW'(CLK_FREQ_HZ - 1);

  logic          w_p_modo;
  logic          w_p_inc;
  logic          w_p_dec;
  logic          w_inc;
  logic          w_dec;
  modo_t         r_state;
  modo_t         w_next;
  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic [5:0]    r_seg;
  logic [5:0]    r_min;
  logic [5:0]    r_hora;

  debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_modo (
    .i_clk  (clk_100MHz),
    .i_rst_n(reset),
    .i_btn  (btn_modo),
    .o_pulse(w_p_modo)
  );

  debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_inc (
    .i_clk  (clk_100MHz),
    .i_rst_n(reset),
    .i_btn  (btn_inc),
    .o_pulse(w_p_inc)
  );

  debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_dec (
    .i_clk  (clk_100MHz),
    .i_rst_n(reset),
    .i_btn  (btn_dec),
    .o_pulse(w_p_dec)
  );

  // Mode beats inc/dec; inc and dec together cancel.
  assign w_inc = w_p_inc & ~w_p_dec & ~w_p_modo;
  assign w_dec = w_p_dec & ~w_p_inc & ~w_p_modo;

  // Mode state register.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) r_state <= RUN;
    else        r_state <= w_next;
  end

  // Mode sequencing: each modo pulse steps the cycle.
  always_comb begin
    w_next = r_state;
    if (w_p_modo) begin
      unique case (r_state)
        RUN:     w_next = AJ_SEG;
        AJ_SEG:  w_next = AJ_MIN;
        AJ_MIN:  w_next = AJ_HORA;
        AJ_HORA: w_next = RUN;
        default: w_next = RUN;
      endcase
    end
  end

  // Prescaler runs only while staying in RUN; a wrap that
  // coincides with leaving RUN is dropped with the count.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (r_state == RUN && w_next == RUN) begin
      if (r_presc == PRE_MAX) begin
        r_presc <= '0;
        r_tick  <= 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
        r_tick  <= 1'b0;
      end
    end else begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end
  end

  // Time fields: carry chain on tick, isolated wrap on adjust.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_seg  <= '0;
      r_min  <= '0;
      r_hora <= '0;
    end else if (r_tick) begin
      r_seg <= inc_wrap(r_seg, MAX_SEG);
      if (r_seg >= MAX_SEG) begin
        r_min <= inc_wrap(r_min, MAX_MIN);
        if (r_min >= MAX_MIN)
          r_hora <= inc_wrap(r_hora, MAX_HORA);
      end
    end else if (w_inc | w_dec) begin
      unique case (r_state)
        AJ_SEG:
          r_seg <= w_inc ? inc_wrap(r_seg, MAX_SEG)
                         : dec_wrap(r_seg, MAX_SEG);
        AJ_MIN:
          r_min <= w_inc ? inc_wrap(r_min, MAX_MIN)
                         : dec_wrap(r_min, MAX_MIN);
        AJ_HORA:
          r_hora <= w_inc ? inc_wrap(r_hora, MAX_HORA)
                          : dec_wrap(r_hora, MAX_HORA);
        default: ;
      endcase
    end
  end

  assign segundos    = r_seg;
  assign minutos     = r_min;
  assign horas       = r_hora;
  assign modo_ajuste = r_state;
  assign tick_1hz    = r_tick;

endmodule
